// File: rtl/airlock_pkg.sv
// Shared airlock definitions: pump sequencer state encoding and default chamber constants.
// Also consumed by the door controllers, so keep encodings stable.
package airlock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRESS = 2'b01,
        EVAC  = 2'b10,
        FAULT = 2'b11
    } airlock_state_t;

    localparam int LEVEL_MAX_DEF   = 15;
    localparam int STEP_CYCLES_DEF = 8;

endpackage

// File: rtl/pump_step_timer.sv
// Pump step pacing counter: counts enabled cycles, ticks for one cycle on the last count of a step.
// Tick is combinational from the count and enable; the counter freezes while enable is low.
module pump_step_timer
    import airlock_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int STEP_W      = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic stepTick
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEP_CYCLES - 1);

    logic [STEP_W-1:0] stepCnt;

    assign stepTick = enable && (stepCnt == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            stepCnt <= '0;
        end else if (enable) begin
            stepCnt <= stepTick ? '0 : stepCnt + STEP_W'(1);
        end
    end

endmodule

// File: rtl/airlock_pressure_ctrl.sv
// Airlock chamber pump sequencer with door interlocks and a latched fault.
// Outputs decode from registered state/level only; one level step every STEP_CYCLES pumping cycles.
module airlock_pressure_ctrl
    import airlock_pkg::*;
#(
    parameter int LEVEL_W     = 4,
    parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int STEP_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pressurizeReq,
    input  logic               evacuateReq,
    input  logic               innerDoor,
    input  logic               outerDoor,
    input  logic               clearFault,
    output logic               pressurized,
    output logic               evacuated,
    output logic               pumping,
    output logic               fault,
    output logic [LEVEL_W-1:0] level
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_ONE = LEVEL_W'(1);

    airlock_state_t     state, state_nxt;
    logic [LEVEL_W-1:0] level_q, level_nxt;
    logic               step_en;
    logic               step_tick;
    logic               step_clr;

    // The step counter only runs while a pump is actually moving; a door trip freezes it.
    assign step_en  = ((state == PRESS) && !outerDoor) || ((state == EVAC) && !innerDoor);
    assign step_clr = rst || !((state == PRESS) || (state == EVAC));

    pump_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .STEP_W      (STEP_W)
    ) u_step_timer (
        .clk      (clk),
        .clear    (step_clr),
        .enable   (step_en),
        .stepTick (step_tick)
    );

    always_comb begin
        state_nxt = state;
        level_nxt = level_q;
        unique case (state)
            IDLE: begin
                if (pressurizeReq && evacuateReq) begin
                    state_nxt = IDLE;
                end else if (pressurizeReq && outerDoor) begin
                    state_nxt = FAULT;
                end else if (evacuateReq && innerDoor) begin
                    state_nxt = FAULT;
                end else if (pressurizeReq && (level_q < LVL_MAX)) begin
                    state_nxt = PRESS;
                end else if (evacuateReq && (level_q != '0)) begin
                    state_nxt = EVAC;
                end
            end
            PRESS: begin
                if (outerDoor) begin
                    state_nxt = FAULT;
                end else if (step_tick) begin
                    level_nxt = level_q + LVL_ONE;
                    if (level_q == LVL_MAX - LVL_ONE) state_nxt = IDLE;
                end
            end
            EVAC: begin
                if (innerDoor) begin
                    state_nxt = FAULT;
                end else if (step_tick) begin
                    level_nxt = level_q - LVL_ONE;
                    if (level_q == LVL_ONE) state_nxt = IDLE;
                end
            end
            FAULT: begin
                if (clearFault && !innerDoor && !outerDoor) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            level_q <= LVL_MAX;
        end else begin
            state   <= state_nxt;
            level_q <= level_nxt;
        end
    end

    assign pressurized = (state == IDLE) && (level_q == LVL_MAX);
    assign evacuated   = (state == IDLE) && (level_q == '0);
    assign pumping     = (state == PRESS) || (state == EVAC);
    assign fault       = (state == FAULT);
    assign level       = level_q;

endmodule

// File: tb/tb_airlock_pressure_ctrl.sv
// Directed bench for the airlock pump sequencer; expected flag/level values are hand-derived.
module tb_airlock_pressure_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pressurizeReq = 1'b0;
    logic       evacuateReq = 1'b0;
    logic       innerDoor = 1'b0;
    logic       outerDoor = 1'b0;
    logic       clearFault = 1'b0;
    logic       pressurized, evacuated, pumping, fault;
    logic [3:0] level;

    int tests_run = 0;
    int tests_failed = 0;

    airlock_pressure_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pressurizeReq (pressurizeReq),
        .evacuateReq   (evacuateReq),
        .innerDoor     (innerDoor),
        .outerDoor     (outerDoor),
        .clearFault    (clearFault),
        .pressurized   (pressurized),
        .evacuated     (evacuated),
        .pumping       (pumping),
        .fault         (fault),
        .level         (level)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got {press,evac,pump,fault,level}=%b_%h, expected %b_%h",
                     tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic chk(input string tag, input logic p, input logic e, input logic pu,
                       input logic f, input logic [3:0] lvl);
        check(tag, {pressurized, evacuated, pumping, fault, level}, {p, e, pu, f, lvl});
    endtask

    initial begin
        // 1: reset state
        cyc(1);
        rst = 1'b0;
        cyc(5);
        chk("reset", 1, 0, 0, 0, 4'd15);

        // 2: full evacuate, then full pressurize (120 cycles each)
        evacuateReq = 1'b1; cyc(1); evacuateReq = 1'b0;
        chk("evac_start", 0, 0, 1, 0, 4'd15);
        cyc(7);
        chk("evac_first_step_pending", 0, 0, 1, 0, 4'd15);
        cyc(1);
        chk("evac_first_step", 0, 0, 1, 0, 4'd14);
        cyc(111);
        chk("evac_k119", 0, 0, 1, 0, 4'd1);
        cyc(1);
        chk("evac_done", 0, 1, 0, 0, 4'd0);

        pressurizeReq = 1'b1; cyc(1); pressurizeReq = 1'b0;
        chk("press_start", 0, 0, 1, 0, 4'd0);
        cyc(119);
        chk("press_k119", 0, 0, 1, 0, 4'd14);
        cyc(1);
        chk("press_done", 1, 0, 0, 0, 4'd15);

        // 3: inner door opened mid-evacuation at level 9
        evacuateReq = 1'b1; cyc(1); evacuateReq = 1'b0;
        cyc(51);
        chk("evac_to_9", 0, 0, 1, 0, 4'd9);
        innerDoor = 1'b1; cyc(1);
        chk("inner_trip", 0, 0, 0, 1, 4'd9);
        cyc(10);
        chk("fault_hold", 0, 0, 0, 1, 4'd9);
        clearFault = 1'b1; cyc(1);
        chk("clear_door_open", 0, 0, 0, 1, 4'd9);
        innerDoor = 1'b0; cyc(1);
        clearFault = 1'b0;
        chk("clear_ok", 0, 0, 0, 0, 4'd9);

        // 4: pressurize request at level 0 with outer door open
        evacuateReq = 1'b1; cyc(1); evacuateReq = 1'b0;
        cyc(72);
        chk("evac_9_to_0", 0, 1, 0, 0, 4'd0);
        pressurizeReq = 1'b1; outerDoor = 1'b1; cyc(1);
        pressurizeReq = 1'b0; outerDoor = 1'b0;
        chk("outer_interlock", 0, 0, 0, 1, 4'd0);
        clearFault = 1'b1; cyc(1); clearFault = 1'b0;
        chk("outer_clear", 0, 1, 0, 0, 4'd0);

        // 5: conflict, ignored opposite request, no-op at target
        pressurizeReq = 1'b1; evacuateReq = 1'b1; cyc(1);
        pressurizeReq = 1'b0; evacuateReq = 1'b0;
        chk("conflict", 0, 1, 0, 0, 4'd0);
        pressurizeReq = 1'b1; cyc(1);
        pressurizeReq = 1'b0; evacuateReq = 1'b1;
        chk("press2_start", 0, 0, 1, 0, 4'd0);
        cyc(20);
        evacuateReq = 1'b0;
        chk("evac_ignored", 0, 0, 1, 0, 4'd2);
        cyc(99);
        chk("press2_k119", 0, 0, 1, 0, 4'd14);
        cyc(1);
        chk("press2_done", 1, 0, 0, 0, 4'd15);
        pressurizeReq = 1'b1; cyc(3); pressurizeReq = 1'b0;
        chk("press_at_max_noop", 1, 0, 0, 0, 4'd15);

        // 6: reset mid-evacuation at level 4, then a clean full evacuation
        evacuateReq = 1'b1; cyc(1); evacuateReq = 1'b0;
        cyc(93);
        chk("evac_to_4", 0, 0, 1, 0, 4'd4);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mid_pump_reset", 1, 0, 0, 0, 4'd15);
        evacuateReq = 1'b1; cyc(1); evacuateReq = 1'b0;
        chk("evac3_start", 0, 0, 1, 0, 4'd15);
        cyc(119);
        chk("evac3_k119", 0, 0, 1, 0, 4'd1);
        cyc(1);
        chk("evac3_done", 0, 1, 0, 0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
